// File: rtl/spi_sr_sched_pkg.sv
// Shared types for the SPI register-access session controller.
// State encoding and command-word field positions.
package spi_sr_sched_pkg;

  localparam int N_DEF = 8;
  localparam int A_DEF = 7;
  localparam int CMD_W_BIT = N_DEF - 1;

  typedef enum logic [2:0] {
    S_IDLE,
    S_CMD,
    S_DECODE,
    S_FETCH,
    S_DATA,
    S_COMMIT,
    S_WAIT_CS
  } state_t;

  function automatic int cmd_w_bit(input int n);
    return n - 1;
  endfunction

endpackage

// File: rtl/spi_pin_sync.sv
// Two-flop synchronisers for the SPI pins plus registered edge pulses.
// Edge pulses appear three clk after the pin changes.
module spi_pin_sync (
  input  logic clk,
  input  logic reset_flag,
  input  logic spi_cs_n,
  input  logic spi_sck,
  input  logic spi_mosi,
  output logic cs_n_s,
  output logic mosi_s,
  output logic sck_rise,
  output logic cs_fall,
  output logic cs_rise
);

  logic [2:0] cs_q;
  logic [2:0] sck_q;
  logic [1:0] mosi_q;

  // Sync chains; third stage is the previous value for edge detection.
  always_ff @(posedge clk or posedge reset_flag) begin
    if (reset_flag) begin
      cs_q     <= 3'b111;
      sck_q    <= 3'b000;
      mosi_q   <= 2'b00;
      cs_n_s   <= 1'b1;
      mosi_s   <= 1'b0;
      sck_rise <= 1'b0;
      cs_fall  <= 1'b0;
      cs_rise  <= 1'b0;
    end else begin
      cs_q     <= {cs_q[1:0], spi_cs_n};
      sck_q    <= {sck_q[1:0], spi_sck};
      mosi_q   <= {mosi_q[0], spi_mosi};
      cs_n_s   <= cs_q[1];
      mosi_s   <= mosi_q[1];
      sck_rise <= sck_q[1] & ~sck_q[2];
      cs_fall  <= ~cs_q[1] & cs_q[2];
      cs_rise  <= cs_q[1] & ~cs_q[2];
    end
  end

endmodule

// File: rtl/spi_sr_sched.sv
// SPI session controller: sequences the external sr for one
// register read or write per chip-select frame.
module spi_sr_sched
  import spi_sr_sched_pkg::*;
#(
  parameter int N = 8,
  parameter int A = 7,
  parameter logic [N-1:0] STATUS_WORD = N'(8'hA5)
) (
  input  logic         clk,
  input  logic         reset_flag,
  input  logic         spi_cs_n,
  input  logic         spi_sck,
  input  logic         spi_mosi,
  output logic         spi_miso,
  output logic         sr_load,
  output logic         sr_sel,
  output logic         sr_si,
  output logic [N-1:0] sr_data_in,
  input  logic         sr_so,
  input  logic         sr_full,
  input  logic [N-1:0] sr_q,
  output logic [A-1:0] reg_addr,
  output logic         reg_re,
  input  logic [N-1:0] reg_rdata,
  output logic         reg_we,
  output logic [N-1:0] reg_wdata,
  output logic         frame_err
);

  localparam int WB = cmd_w_bit(N);

  logic cs_n_s;
  logic mosi_s;
  logic sck_rise;
  logic cs_fall;
  logic cs_rise;

  state_t state;
  state_t next;
  logic   w_flag;
  logic   fetch_rdy;
  logic   fetch_rdy_n;
  logic   re_set;
  logic   latch;
  logic   fe_set;
  logic   fe_clr;

  spi_pin_sync u_sync (
    .clk        (clk),
    .reset_flag (reset_flag),
    .spi_cs_n   (spi_cs_n),
    .spi_sck    (spi_sck),
    .spi_mosi   (spi_mosi),
    .cs_n_s     (cs_n_s),
    .mosi_s     (mosi_s),
    .sck_rise   (sck_rise),
    .cs_fall    (cs_fall),
    .cs_rise    (cs_rise)
  );

  // State, command latch, read strobe and sticky frame error.
  always_ff @(posedge clk or posedge reset_flag) begin
    if (reset_flag) begin
      state     <= S_IDLE;
      w_flag    <= 1'b0;
      fetch_rdy <= 1'b0;
      reg_re    <= 1'b0;
      reg_addr  <= '0;
      frame_err <= 1'b0;
    end else begin
      state     <= next;
      fetch_rdy <= fetch_rdy_n;
      reg_re    <= re_set;
      if (latch) begin
        reg_addr <= sr_q[A-1:0];
        w_flag   <= sr_q[WB];
      end
      if (fe_clr) begin
        frame_err <= 1'b0;
        reg_addr  <= '0;
      end else if (fe_set) begin
        frame_err <= 1'b1;
      end
    end
  end

  // Next state plus the sr / register-bus strobes.
  always_comb begin
    next        = state;
    sr_load     = 1'b0;
    sr_sel      = 1'b0;
    sr_si       = 1'b0;
    sr_data_in  = STATUS_WORD;
    reg_we      = 1'b0;
    reg_wdata   = '0;
    re_set      = 1'b0;
    latch       = 1'b0;
    fe_set      = 1'b0;
    fe_clr      = 1'b0;
    fetch_rdy_n = 1'b0;
    spi_miso    = 1'b0;
    unique case (state)
      S_IDLE: begin
        if (cs_fall) begin
          sr_load = 1'b1;
          fe_clr  = 1'b1;
          next    = S_CMD;
        end
      end
      S_CMD, S_DATA: begin
        spi_miso = sr_so & ~cs_n_s;
        if (cs_rise) begin
          fe_set = 1'b1;
          next   = S_IDLE;
        end else if (sr_full) begin
          next = (state == S_CMD) ? S_DECODE : S_COMMIT;
        end else if (sck_rise) begin
          sr_sel = 1'b1;
          sr_si  = mosi_s;
        end
      end
      S_DECODE: begin
        spi_miso = sr_so & ~cs_n_s;
        if (cs_rise) begin
          fe_set = 1'b1;
          next   = S_IDLE;
        end else begin
          latch       = 1'b1;
          re_set      = ~sr_q[WB];
          fetch_rdy_n = sr_q[WB];
          next        = S_FETCH;
        end
      end
      S_FETCH: begin
        spi_miso = sr_so & ~cs_n_s;
        if (cs_rise) begin
          fe_set = 1'b1;
          next   = S_IDLE;
        end else if (fetch_rdy) begin
          sr_load    = 1'b1;
          sr_data_in = w_flag ? '0 : reg_rdata;
          next       = S_DATA;
        end else begin
          fetch_rdy_n = 1'b1;
        end
      end
      S_COMMIT: begin
        if (cs_rise) begin
          next = S_IDLE;
        end else begin
          reg_we    = w_flag;
          reg_wdata = w_flag ? sr_q : '0;
          next      = S_WAIT_CS;
        end
      end
      S_WAIT_CS: begin
        if (cs_rise) next = S_IDLE;
      end
      default: next = S_IDLE;
    endcase
  end

endmodule

// File: tb/tb_spi_sr_sched.sv
// Randomised frame-level bench for spi_sr_sched.
// Includes a behavioural sr and register file around the DUT.
module tb_spi_sr_sched;
  import spi_sr_sched_pkg::*;

  localparam int N = 8;
  localparam int A = 7;

  logic         clk = 1'b0;
  logic         reset_flag = 1'b1;
  logic         spi_cs_n = 1'b1;
  logic         spi_sck = 1'b0;
  logic         spi_mosi = 1'b0;
  logic         spi_miso;
  logic         sr_load;
  logic         sr_sel;
  logic         sr_si;
  logic [N-1:0] sr_data_in;
  logic         sr_so;
  logic         sr_full = 1'b0;
  logic [N-1:0] sr_q = '0;
  logic [A-1:0] reg_addr;
  logic         reg_re;
  logic [N-1:0] reg_rdata = '0;
  logic         reg_we;
  logic [N-1:0] reg_wdata;
  logic         frame_err;

  spi_sr_sched dut (
    .clk        (clk),
    .reset_flag (reset_flag),
    .spi_cs_n   (spi_cs_n),
    .spi_sck    (spi_sck),
    .spi_mosi   (spi_mosi),
    .spi_miso   (spi_miso),
    .sr_load    (sr_load),
    .sr_sel     (sr_sel),
    .sr_si      (sr_si),
    .sr_data_in (sr_data_in),
    .sr_so      (sr_so),
    .sr_full    (sr_full),
    .sr_q       (sr_q),
    .reg_addr   (reg_addr),
    .reg_re     (reg_re),
    .reg_rdata  (reg_rdata),
    .reg_we     (reg_we),
    .reg_wdata  (reg_wdata),
    .frame_err  (frame_err)
  );

  always #5 clk = ~clk;

  // Behavioural sr: MSB-first shifter, full after N shifts.
  logic [N-1:0] sr_sh = '0;
  int           sr_cnt = 0;
  assign sr_so = sr_sh[N-1];

  always @(posedge clk) begin
    if (sr_load) begin
      sr_sh   <= sr_data_in;
      sr_cnt  <= 0;
      sr_full <= 1'b0;
    end else if (sr_sel) begin
      sr_sh  <= {sr_sh[N-2:0], sr_si};
      sr_cnt <= sr_cnt + 1;
      if (sr_cnt == N - 1) begin
        sr_full <= 1'b1;
        sr_q    <= {sr_sh[N-2:0], sr_si};
      end
    end
  end

  // Register file seen by the DUT, and the reference copy.
  logic [N-1:0] mem [128];
  logic [N-1:0] ref_mem [128];

  always @(posedge clk) begin
    if (reg_re) reg_rdata <= mem[reg_addr];
    if (reg_we) mem[reg_addr] <= reg_wdata;
  end

  // Strobe counters.
  int         n_load = 0;
  int         n_sel = 0;
  int         n_re = 0;
  int         n_we = 0;
  int         n_both = 0;
  logic [6:0] re_addr = '0;
  logic [6:0] we_addr = '0;
  logic [7:0] we_data = '0;
  logic [2:0] we_state = '0;

  always @(posedge clk) begin
    if (!reset_flag) begin
      if (sr_load) n_load++;
      if (sr_sel) n_sel++;
      if (sr_load && sr_sel) n_both++;
      if (reg_re) begin
        n_re++;
        re_addr = reg_addr;
      end
      if (reg_we) begin
        n_we++;
        we_addr  = reg_addr;
        we_data  = reg_wdata;
        we_state = dut.state;
      end
    end
  end

  int n_tests = 0;
  int n_fail = 0;

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic xfer(input logic b, output logic m);
    spi_mosi = b;
    tick(4);
    m = spi_miso;
    spi_sck = 1'b1;
    tick(4);
    spi_sck = 1'b0;
  endtask

  task automatic run_frame(input logic [7:0] cmd, input logic [7:0] dat,
                           input int nbits, input int gap);
    logic [23:0] tx;
    logic [15:0] rx;
    logic        m;
    logic        w;
    logic [6:0]  addr;
    logic [7:0]  exp_rd;
    int          l0, s0, r0, w0;
    int          exp_sel;
    l0 = n_load;
    s0 = n_sel;
    r0 = n_re;
    w0 = n_we;
    tx = {cmd, dat, 8'($urandom)};
    rx = '0;
    w = cmd[7];
    addr = cmd[6:0];
    exp_rd = ref_mem[addr];
    spi_cs_n = 1'b0;
    tick(4);
    for (int i = 0; i < nbits; i++) begin
      xfer(tx[23-i], m);
      if (i < 16) rx[15-i] = m;
    end
    tick(6);
    spi_cs_n = 1'b1;
    tick(gap);
    exp_sel = (nbits > 16) ? 16 : nbits;
    if (nbits >= 8) chk("miso_status", rx[15:8], 8'hA5);
    if (nbits >= 16) chk("miso_data", rx[7:0], w ? 8'h00 : exp_rd);
    chk("re_cnt", n_re - r0, (!w && nbits >= 8) ? 1 : 0);
    if (!w && nbits >= 8) chk("re_addr", re_addr, addr);
    chk("we_cnt", n_we - w0, (w && nbits >= 16) ? 1 : 0);
    if (w && nbits >= 16) begin
      chk("we_addr", we_addr, addr);
      chk("we_data", we_data, dat);
      chk("we_in_commit", we_state, S_COMMIT);
      ref_mem[addr] = dat;
    end
    chk("load_cnt", n_load - l0, (nbits >= 8) ? 2 : 1);
    chk("sel_cnt", n_sel - s0, exp_sel);
    chk("frame_err", frame_err, (nbits < 16) ? 1 : 0);
  endtask

  int lens [7] = '{16, 16, 16, 8, 12, 20, 5};

  initial begin
    logic m;
    for (int i = 0; i < 128; i++) begin
      mem[i] = 8'($urandom);
      ref_mem[i] = mem[i];
    end
    mem[7'h12] = 8'h3C;
    ref_mem[7'h12] = 8'h3C;

    tick(3);
    chk("rst_outs", {spi_miso, sr_load, sr_sel, sr_si, reg_re, reg_we,
                     frame_err}, 0);
    chk("rst_data_in", sr_data_in, 8'hA5);
    reset_flag = 1'b0;
    tick(4);

    // Read of 0x12, write 0xE7 to 0x05.
    run_frame(8'h12, 8'h00, 16, 8);
    run_frame(8'h85, 8'hE7, 16, 8);
    run_frame(8'h05, 8'h00, 16, 8);

    // Abort four bits into the data word of a write.
    run_frame(8'h85, 8'h11, 12, 5);
    chk("abort_idle", dut.state, S_IDLE);
    run_frame(8'h05, 8'h00, 16, 8);

    // Extra sck edges after the data word.
    run_frame(8'hA0, 8'h5A, 20, 8);

    // Asynchronous reset in the middle of the data phase.
    spi_cs_n = 1'b0;
    tick(4);
    for (int i = 0; i < 8; i++) xfer(1'(8'h9A >> (7 - i)), m);
    for (int i = 0; i < 3; i++) xfer(1'b1, m);
    tick(1);
    chk("pre_rst_addr", reg_addr, 7'h1A);
    #2 reset_flag = 1'b1;
    #1;
    chk("mid_rst_outs", {spi_miso, sr_load, sr_sel, sr_si, reg_re, reg_we,
                         frame_err}, 0);
    chk("mid_rst_addr", reg_addr, 0);
    chk("mid_rst_wdata", reg_wdata, 0);
    chk("mid_rst_data_in", sr_data_in, 8'hA5);
    spi_cs_n = 1'b1;
    tick(3);
    reset_flag = 1'b0;
    tick(4);
    run_frame(8'h1A, 8'h00, 16, 4);

    // Back-to-back frames with four clk of CS high.
    run_frame(8'h92, 8'h77, 16, 4);
    run_frame(8'h12, 8'h00, 16, 8);

    // Random frames.
    for (int k = 0; k < 12; k++) begin
      run_frame(8'($urandom), 8'($urandom),
                lens[$urandom_range(0, 6)], $urandom_range(4, 8));
    end

    chk("load_sel_overlap", n_both, 0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
